// File: rtl/calc_le_div_pkg.sv
// -----------------------------------------------------------------------------
// calc_le_div_pkg
// Shared constants and types for the r-offset sequential divider.
//   DIN0_W / DIN1_W / DOUT_W : dividend, divisor and quotient widths
//   QMAX / QMIN              : representable signed quotient range
//   CNT_W                    : iteration counter width (holds DIN0_W-1)
//   state_e                  : divider control states
// -----------------------------------------------------------------------------
package calc_le_div_pkg;

   localparam int DIN0_W = 32'sd33;
   localparam int DIN1_W = 32'sd15;
   localparam int DOUT_W = 32'sd18;

   localparam int QMAX = 32'sd131071;
   localparam int QMIN = -32'sd131072;

   localparam int CNT_W = 32'sd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/calc_le_div_step.sv
// -----------------------------------------------------------------------------
// calc_le_div_step
// One combinational restoring-division step on unsigned magnitudes.
//   pr_in   : current partial remainder (DVS_W+1 bits, always < dvs)
//   dvd_bit : next dividend bit, shifted in at the LSB
//   dvs     : divisor magnitude
//   pr_out  : next partial remainder
//   q_bit   : quotient bit produced by this step
// -----------------------------------------------------------------------------
module calc_le_div_step
   import calc_le_div_pkg::*;
#(
   parameter int DVS_W = DIN1_W
) (
   input  logic [DVS_W:0]   pr_in,
   input  logic             dvd_bit,
   input  logic [DVS_W-1:0] dvs,
   output logic [DVS_W:0]   pr_out,
   output logic             q_bit
);

   // One extra bit above the partial remainder so the shift never loses data.
   logic [DVS_W+1:0] shift_s;
   logic [DVS_W+1:0] dvs_ext_s;

   // Shift in the dividend bit, subtract the divisor when it fits, else restore.
   always_comb begin
      shift_s   = {pr_in, dvd_bit};
      dvs_ext_s = {2'b00, dvs};
      if (shift_s >= dvs_ext_s) begin
         pr_out = (DVS_W+1)'(shift_s - dvs_ext_s);
         q_bit  = 1'b1;
      end else begin
         pr_out = (DVS_W+1)'(shift_s);
         q_bit  = 1'b0;
      end
   end

endmodule

// File: rtl/calc_le_r_offset_div.sv
// -----------------------------------------------------------------------------
// calc_le_r_offset_div
// Sequential signed divider (quotient = din0 / din1, remainder = din0 % din1)
// recovering the 18-bit r-offset factor from its 33x15 product. One quotient
// bit per clock, ap_start/ap_ready/ap_idle/ap_done handshake.
//   ap_clk, ap_rst_n  : clock, asynchronous active-low reset
//   ap_start/ap_ready : request / accept strobe (din0, din1 sampled on accept)
//   ap_idle           : controller in IDLE
//   ap_done           : one-cycle pulse, dout/rem/div_zero/ovf valid
//   din0, din1        : signed dividend, signed divisor
//   dout, rem         : signed quotient (truncated toward zero), remainder
//                       carrying the sign of din0
//   div_zero          : din1 was zero
//   ovf               : quotient out of range (only with saturation build)
// Build option: define CALC_LE_DIV_SAT_EN to saturate dout to QMIN..QMAX and
// flag ovf; otherwise dout wraps to its low DOUT_WIDTH bits and ovf is 0.
// -----------------------------------------------------------------------------
module calc_le_r_offset_div
   import calc_le_div_pkg::*;
#(
   parameter int DIN0_WIDTH = DIN0_W,
   parameter int DIN1_WIDTH = DIN1_W,
   parameter int DOUT_WIDTH = DOUT_W
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   input  logic                         ap_start,
   output logic                         ap_ready,
   output logic                         ap_idle,
   output logic                         ap_done,
   input  logic signed [DIN0_WIDTH-1:0] din0,
   input  logic signed [DIN1_WIDTH-1:0] din1,
   output logic signed [DOUT_WIDTH-1:0] dout,
   output logic signed [DIN1_WIDTH-1:0] rem,
   output logic                         div_zero,
   output logic                         ovf
);

   localparam logic [CNT_W-1:0]             CNT_LOAD = CNT_W'(DIN0_WIDTH - 1);
   localparam logic signed [DOUT_WIDTH-1:0] QMAX_V   = DOUT_WIDTH'(QMAX);
   localparam logic signed [DOUT_WIDTH-1:0] QMIN_V   = DOUT_WIDTH'(QMIN);

   state_e                  state_r;
   logic [CNT_W-1:0]        cnt_r;
   logic [DIN0_WIDTH-1:0]   dvd_r;      // |din0|, progressively replaced by quotient bits
   logic [DIN1_WIDTH-1:0]   dvs_r;      // |din1|
   logic [DIN1_WIDTH:0]     pr_r;       // partial remainder
   logic                    neg_q_r;
   logic                    sign0_r;
   logic                    dz_r;
   logic [DIN1_WIDTH-1:0]   din0_lo_r;  // remainder value reported on divide by zero
   logic signed [DOUT_WIDTH-1:0] dout_r;
   logic signed [DIN1_WIDTH-1:0] rem_r;
   logic                    div_zero_r;
   logic                    ap_done_r;

   logic [DIN0_WIDTH-1:0]   abs0_s;
   logic [DIN1_WIDTH-1:0]   abs1_s;
   logic [DIN1_WIDTH:0]     pr_next_s;
   logic                    q_bit_s;
   logic signed [DOUT_WIDTH-1:0] dout_s;
   logic signed [DIN1_WIDTH-1:0] rem_s;

`ifdef CALC_LE_DIV_SAT_EN
   localparam logic signed [DIN0_WIDTH:0] QMAX_X = (DIN0_WIDTH+1)'(QMAX);
   localparam logic signed [DIN0_WIDTH:0] QMIN_X = (DIN0_WIDTH+1)'(QMIN);
   logic signed [DIN0_WIDTH:0] q_full_s;
   logic                       ovf_s;
   logic                       ovf_r;
`endif

   calc_le_div_step #(
      .DVS_W   (DIN1_WIDTH)
   ) u_step (
      .pr_in   (pr_r),
      .dvd_bit (dvd_r[DIN0_WIDTH-1]),
      .dvs     (dvs_r),
      .pr_out  (pr_next_s),
      .q_bit   (q_bit_s)
   );

   // Operand magnitudes; the most negative dividend maps to 2^(W-1) unsigned.
   always_comb begin
      if (din0[DIN0_WIDTH-1]) begin
         abs0_s = -din0;
      end else begin
         abs0_s = din0;
      end
      if (din1[DIN1_WIDTH-1]) begin
         abs1_s = -din1;
      end else begin
         abs1_s = din1;
      end
   end

   // Sign fix-up, divide-by-zero override and range handling of the result.
   always_comb begin
      dout_s = '0;
      rem_s  = '0;
`ifdef CALC_LE_DIV_SAT_EN
      q_full_s = '0;
      ovf_s    = 1'b0;
`endif
      if (dz_r) begin
         dout_s = sign0_r ? QMIN_V : QMAX_V;
         rem_s  = din0_lo_r;
      end else begin
         if (sign0_r) begin
            rem_s = -pr_r[DIN1_WIDTH-1:0];
         end else begin
            rem_s = pr_r[DIN1_WIDTH-1:0];
         end
`ifdef CALC_LE_DIV_SAT_EN
         if (neg_q_r) begin
            q_full_s = -$signed({1'b0, dvd_r});
         end else begin
            q_full_s = $signed({1'b0, dvd_r});
         end
         if (q_full_s > QMAX_X) begin
            dout_s = QMAX_V;
            ovf_s  = 1'b1;
         end else if (q_full_s < QMIN_X) begin
            dout_s = QMIN_V;
            ovf_s  = 1'b1;
         end else begin
            dout_s = q_full_s[DOUT_WIDTH-1:0];
         end
`else
         // Low bits of a two's-complement negation depend only on low bits.
         if (neg_q_r) begin
            dout_s = DOUT_WIDTH'(-dvd_r);
         end else begin
            dout_s = dvd_r[DOUT_WIDTH-1:0];
         end
`endif
      end
   end

   // Controller, datapath registers and registered result outputs.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_r    <= IDLE;
         cnt_r      <= '0;
         dvd_r      <= '0;
         dvs_r      <= '0;
         pr_r       <= '0;
         neg_q_r    <= 1'b0;
         sign0_r    <= 1'b0;
         dz_r       <= 1'b0;
         din0_lo_r  <= '0;
         dout_r     <= '0;
         rem_r      <= '0;
         div_zero_r <= 1'b0;
         ap_done_r  <= 1'b0;
`ifdef CALC_LE_DIV_SAT_EN
         ovf_r      <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               ap_done_r <= 1'b0;
               if (ap_start) begin
                  state_r   <= DIV;
                  cnt_r     <= CNT_LOAD;
                  dvd_r     <= abs0_s;
                  dvs_r     <= abs1_s;
                  pr_r      <= '0;
                  neg_q_r   <= din0[DIN0_WIDTH-1] ^ din1[DIN1_WIDTH-1];
                  sign0_r   <= din0[DIN0_WIDTH-1];
                  dz_r      <= (din1 == '0);
                  din0_lo_r <= din0[DIN1_WIDTH-1:0];
               end
            end
            DIV: begin
               pr_r  <= pr_next_s;
               dvd_r <= {dvd_r[DIN0_WIDTH-2:0], q_bit_s};
               if (cnt_r == '0) begin
                  state_r <= SIGN;
               end else begin
                  cnt_r <= cnt_r - 1'b1;
               end
            end
            SIGN: begin
               dout_r     <= dout_s;
               rem_r      <= rem_s;
               div_zero_r <= dz_r;
`ifdef CALC_LE_DIV_SAT_EN
               ovf_r      <= ovf_s;
`endif
               ap_done_r  <= 1'b1;
               state_r    <= DONE;
            end
            DONE: begin
               ap_done_r <= 1'b0;
               state_r   <= IDLE;
            end
            default: begin
               ap_done_r <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

   assign ap_ready = ap_start & (state_r == IDLE);
   assign ap_idle  = (state_r == IDLE);
   assign ap_done  = ap_done_r;
   assign dout     = dout_r;
   assign rem      = rem_r;
   assign div_zero = div_zero_r;
`ifdef CALC_LE_DIV_SAT_EN
   assign ovf      = ovf_r;
`else
   assign ovf      = 1'b0;
`endif

endmodule

// File: doc/calc_le_r_offset_div.md
Name: calc_le_r_offset_div

Overview:
- Sequential signed divider for the Legendre-segment-finder r-offset path; the inverse of the 18x15 signed r-offset multiply.
- Recovers an 18-bit factor from a 33-bit signed product and a 15-bit signed multiplier: quotient = din0 / din1, remainder = din0 % din1.
- Iterative restoring divider, one quotient bit per clock, controlled with the ap_start/ap_done/ap_idle/ap_ready handshake used by the LSF HLS cores.

Parameters:
- DIN0_WIDTH, 33, signed dividend width
- DIN1_WIDTH, 15, signed divisor width
- DOUT_WIDTH, 18, signed quotient width

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst_n  in  1  asynchronous active-low reset
- ap_start  in  1  request; din0/din1 sampled when accepted
- ap_ready  out  1  high in the cycle ap_start is accepted
- ap_idle  out  1  high while in IDLE
- ap_done  out  1  one-cycle pulse, results valid
- din0  in  DIN0_WIDTH  signed dividend
- din1  in  DIN1_WIDTH  signed divisor
- dout  out  DOUT_WIDTH  signed quotient
- rem  out  DIN1_WIDTH  signed remainder
- div_zero  out  1  set with ap_done when din1 == 0
- ovf  out  1  quotient out of DOUT_WIDTH range (tied 0 unless CALC_LE_DIV_SAT_EN)

Behaviour:
- Reset (asynchronous, any state): state = IDLE, ap_done = 0, dout = 0, rem = 0, div_zero = 0, ovf = 0, counter = 0.
- States:
  - IDLE: ap_idle = 1.
  - DIV: W = DIN0_WIDTH iterations.
  - SIGN: sign fix-up and range check.
  - DONE: ap_done = 1 for one cycle.
- Transitions:
  - IDLE -> DIV on ap_start.
  - DIV -> SIGN when counter reaches 0.
  - SIGN -> DONE.
  - DONE -> IDLE.
- ap_ready = ap_start & (state == IDLE), combinational.
- On accept, register |din0|, |din1|, both signs and the div_zero condition. Inputs may change afterwards.
- ap_start outside IDLE is ignored (no queueing).
- Latency: if ap_start is sampled in cycle 0, ap_done is high in cycle W+2 (cycle 35 at defaults). Throughput is one op per W+3 cycles.
- Arithmetic:
  - Unsigned restoring division on magnitudes. The partial remainder is DIN1_WIDTH+1 bits, so |din1| = 2^14 and the |din0| = 2^32 case need no extra width.
  - Quotient truncates toward zero. Quotient is negated iff the signs differ.
  - Remainder takes the sign of din0 (C semantics).
- Range:
  - Without the macro, dout is the low DOUT_WIDTH bits of the full quotient (wraps, matches HLS C-sim truncation).
  - Valid quotient range is -131072..131071.
- Divide by zero:
  - div_zero = 1, rem = din0 low DIN1_WIDTH bits.
  - dout = 131071 if din0 >= 0, else -131072.
  - The DIV state still runs W cycles, so latency is constant.
- dout, rem, div_zero and ovf update on the SIGN->DONE edge and hold until the next op's SIGN->DONE edge.
- Reset mid-operation aborts the op with no ap_done. The next ap_start after release behaves normally.

Optional Feature:
- Macro: CALC_LE_DIV_SAT_EN.
- Defined:
  - Quotient above 131071 -> dout = 131071, ovf = 1.
  - Quotient below -131072 -> dout = -131072, ovf = 1.
  - ovf is registered with dout.
- Undefined: wrap as above, ovf constant 0, no saturation logic synthesised.

Decomposition:
- Package calc_le_div_pkg holds:
  - width constants (33/15/18);
  - QMAX = 131071, QMIN = -131072;
  - the state enum {IDLE, DIV, SIGN, DONE}.
- Sub-module calc_le_div_step: purely combinational single restoring step. It takes the partial remainder, next dividend bit and |divisor|, and returns the next partial remainder and quotient bit. The top holds the FSM, counter and registers.

Test Plan:
- din0 = 1000000, din1 = 100 -> dout = 10000, rem = 0, ap_done exactly 35 cycles after accept, ap_ready pulsed once.
- Signs:
  - -7/2 -> dout = -3, rem = -1.
  - 7/-2 -> dout = -3, rem = 1.
  - -7/-2 -> dout = 3, rem = -1.
- din0 = 2^30, din1 = 1:
  - without macro -> dout = 0, ovf = 0.
  - with CALC_LE_DIV_SAT_EN -> dout = 131071, ovf = 1.
  - Also din0 = -2^32, din1 = 1 -> saturates to -131072 with the macro.
- Divide by zero:
  - 5/0 -> div_zero = 1, dout = 131071.
  - -5/0 -> div_zero = 1, dout = -131072.
  - Latency still 35.
- Drop ap_rst_n in DIV cycle 10 -> ap_idle = 1, all outputs 0, no ap_done. New start 12/4 -> dout = 3, rem = 0.
- ap_start held high continuously over three ops with different inputs:
  - ap_done pulses at 35, 71, 107 cycles after the first accept;
  - each result matches the inputs sampled at its own accept;
  - starts during busy are ignored.
